// File: rtl/vram_arbiter_if.sv
// Bus bundle between vram_arbiter and its three neighbours: scanout fetch,
// CPU bus interface and the VRAM macro.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  scan_req;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  scan_gnt;
  logic                  scan_valid;
  logic [DATA_WIDTH-1:0] scan_data;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  vram_en;
  logic                  vram_we;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_wdata;
  logic [DATA_WIDTH-1:0] vram_rdata;

  modport slave (
    input  scan_req, scan_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output scan_gnt, scan_valid, scan_data, cpu_ack, cpu_rdata,
           vram_en, vram_we, vram_addr, vram_wdata
  );

  modport master (
    output scan_req, scan_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  scan_gnt, scan_valid, scan_data, cpu_ack, cpu_rdata,
           vram_en, vram_we, vram_addr, vram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout wins in active video, CPU wins in blanking,
// with a starvation counter forcing a CPU slot during long active periods.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           blank,
  vram_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                  cpu_elig_s;
  logic                  starved_s;
  logic                  scan_sel_s;
  logic                  cpu_sel_s;
  logic                  cpu_busy_r;
  logic [CNT_W-1:0]      starve_cnt_r;
  logic                  vram_en_r;
  logic                  vram_we_r;
  logic [ADDR_WIDTH-1:0] vram_addr_r;
  logic [DATA_WIDTH-1:0] vram_wdata_r;
  logic                  tag1_scan_r;
  logic                  tag1_rd_r;
  logic                  tag1_wr_r;
  logic                  tag2_scan_r;
  logic                  tag2_rd_r;
  logic                  scan_valid_r;
  logic [DATA_WIDTH-1:0] scan_data_r;
  logic                  cpu_ack_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;

  // Grant decision: blanking or starvation hands first choice to the CPU
  always_comb begin
    cpu_elig_s = bus.cpu_req & ~cpu_busy_r;
    starved_s  = (starve_cnt_r >= CNT_W'(STARVE_LIMIT));
    scan_sel_s = 1'b0;
    cpu_sel_s  = 1'b0;
    if (blank || starved_s) begin
      if (cpu_elig_s) begin
        cpu_sel_s = 1'b1;
      end else begin
        scan_sel_s = bus.scan_req;
      end
    end else begin
      if (bus.scan_req) begin
        scan_sel_s = 1'b1;
      end else begin
        cpu_sel_s = cpu_elig_s;
      end
    end
  end

  assign bus.scan_gnt = scan_sel_s & ~reset;

  // VRAM command issue, one cycle after the decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_en_r    <= 1'b0;
      vram_we_r    <= 1'b0;
      vram_addr_r  <= '0;
      vram_wdata_r <= '0;
    end else begin
      vram_en_r <= scan_sel_s | cpu_sel_s;
      if (cpu_sel_s) begin
        vram_we_r    <= bus.cpu_we;
        vram_addr_r  <= bus.cpu_addr;
        vram_wdata_r <= bus.cpu_wdata;
      end else if (scan_sel_s) begin
        vram_we_r   <= 1'b0;
        vram_addr_r <= bus.scan_addr;
      end else begin
        vram_we_r <= 1'b0;
      end
    end
  end

  // Ownership tags follow each command so read data lands at its requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_scan_r <= 1'b0;
      tag1_rd_r   <= 1'b0;
      tag1_wr_r   <= 1'b0;
      tag2_scan_r <= 1'b0;
      tag2_rd_r   <= 1'b0;
    end else begin
      tag1_scan_r <= scan_sel_s;
      tag1_rd_r   <= cpu_sel_s & ~bus.cpu_we;
      tag1_wr_r   <= cpu_sel_s & bus.cpu_we;
      tag2_scan_r <= tag1_scan_r;
      tag2_rd_r   <= tag1_rd_r;
    end
  end

  // Read-data routing and completion pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_valid_r <= 1'b0;
      scan_data_r  <= '0;
      cpu_ack_r    <= 1'b0;
      cpu_rdata_r  <= '0;
    end else begin
      scan_valid_r <= tag2_scan_r;
      cpu_ack_r    <= tag1_wr_r | tag2_rd_r;
      if (tag2_scan_r) begin
        scan_data_r <= bus.vram_rdata;
      end
      if (tag2_rd_r) begin
        cpu_rdata_r <= bus.vram_rdata;
      end
    end
  end

  // CPU busy window and starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_busy_r   <= 1'b0;
      starve_cnt_r <= '0;
    end else begin
      if (cpu_sel_s) begin
        cpu_busy_r <= 1'b1;
      end else if (cpu_ack_r) begin
        cpu_busy_r <= 1'b0;
      end
      if (cpu_sel_s) begin
        starve_cnt_r <= '0;
      end else if (cpu_elig_s && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.vram_en    = vram_en_r;
  assign bus.vram_we    = vram_we_r;
  assign bus.vram_addr  = vram_addr_r;
  assign bus.vram_wdata = vram_wdata_r;
  assign bus.scan_valid = scan_valid_r;
  assign bus.scan_data  = scan_data_r;
  assign bus.cpu_ack    = cpu_ack_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-indexed expectation schedule built from the arbitration rules.
module tb_vram_arbiter;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int LIMIT = 16;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic reset;
  logic blank;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .blank (blank),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // VRAM macro: synchronous read, write on en&we
  logic [DW-1:0] vram_mem [1024];
  always @(posedge clk) begin
    if (bus.vram_en) begin
      if (bus.vram_we) vram_mem[bus.vram_addr[9:0]] = bus.vram_wdata;
      else             bus.vram_rdata <= vram_mem[bus.vram_addr[9:0]];
    end
  end

  // Reference model state and expectation schedule
  logic [DW-1:0] ref_mem [1024];
  bit            exp_en   [MAXC];
  bit            exp_we   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [DW-1:0] exp_wd   [MAXC];
  bit            exp_sv   [MAXC];
  logic [DW-1:0] exp_sd   [MAXC];
  bit            exp_ack  [MAXC];
  bit            exp_rdv  [MAXC];
  logic [DW-1:0] exp_rd   [MAXC];
  bit            m_busy;
  int            m_starve;
  logic [DW-1:0] m_rdata;
  int            cyc;
  bit            last_ack, last_sg;
  logic          obs_gnt, obs_sv, obs_ack, obs_en;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    bit elig, cg, sg;
    @(negedge clk);
    obs_gnt = bus.scan_gnt;
    obs_sv  = bus.scan_valid;
    obs_ack = bus.cpu_ack;
    obs_en  = bus.vram_en;
    if (reset) begin
      check_eq("rst_ctrl", {27'd0, bus.scan_gnt, bus.scan_valid, bus.cpu_ack, bus.vram_en, bus.vram_we}, 32'd0);
      check_eq("rst_data", {8'd0, bus.scan_data, bus.cpu_rdata, bus.vram_wdata}, 32'd0);
      check_eq("rst_addr", {13'd0, bus.vram_addr}, 32'd0);
      last_ack = 1'b0;
      last_sg  = 1'b0;
    end else begin
      check_eq("vram_en", {31'd0, bus.vram_en}, {31'd0, exp_en[cyc]});
      if (exp_en[cyc]) begin
        check_eq("vram_we", {31'd0, bus.vram_we}, {31'd0, exp_we[cyc]});
        check_eq("vram_addr", {13'd0, bus.vram_addr}, {13'd0, exp_addr[cyc]});
        if (exp_we[cyc]) check_eq("vram_wdata", {24'd0, bus.vram_wdata}, {24'd0, exp_wd[cyc]});
      end
      check_eq("scan_valid", {31'd0, bus.scan_valid}, {31'd0, exp_sv[cyc]});
      if (exp_sv[cyc]) check_eq("scan_data", {24'd0, bus.scan_data}, {24'd0, exp_sd[cyc]});
      check_eq("cpu_ack", {31'd0, bus.cpu_ack}, {31'd0, exp_ack[cyc]});
      if (exp_rdv[cyc]) m_rdata = exp_rd[cyc];
      check_eq("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, m_rdata});
      // Arbitration rules applied to this cycle's inputs
      elig = bus.cpu_req && !m_busy;
      if (blank || m_starve >= LIMIT) begin
        cg = elig;
        sg = bus.scan_req && !cg;
      end else begin
        sg = bus.scan_req;
        cg = elig && !sg;
      end
      check_eq("scan_gnt", {31'd0, bus.scan_gnt}, {31'd0, sg});
      if (sg) begin
        exp_en[cyc+1]   = 1'b1;
        exp_we[cyc+1]   = 1'b0;
        exp_addr[cyc+1] = bus.scan_addr;
        exp_sv[cyc+3]   = 1'b1;
        exp_sd[cyc+3]   = ref_mem[bus.scan_addr[9:0]];
      end
      if (cg) begin
        exp_en[cyc+1]   = 1'b1;
        exp_we[cyc+1]   = bus.cpu_we;
        exp_addr[cyc+1] = bus.cpu_addr;
        exp_wd[cyc+1]   = bus.cpu_wdata;
        if (bus.cpu_we) begin
          ref_mem[bus.cpu_addr[9:0]] = bus.cpu_wdata;
          exp_ack[cyc+2] = 1'b1;
        end else begin
          exp_ack[cyc+3] = 1'b1;
          exp_rdv[cyc+3] = 1'b1;
          exp_rd[cyc+3]  = ref_mem[bus.cpu_addr[9:0]];
        end
      end
      last_ack = exp_ack[cyc];
      last_sg  = sg;
      if (cg) m_busy = 1'b0 | 1'b1;
      else if (exp_ack[cyc]) m_busy = 1'b0;
      if (cg) m_starve = 0;
      else if (elig && m_starve < LIMIT) m_starve++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset        = 1'b1;
    bus.scan_req = 1'b0;
    bus.cpu_req  = 1'b0;
    for (int i = cyc; i < MAXC; i++) begin
      exp_en[i] = 1'b0; exp_sv[i] = 1'b0; exp_ack[i] = 1'b0; exp_rdv[i] = 1'b0;
    end
    m_busy   = 1'b0;
    m_starve = 0;
    m_rdata  = '0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic cpu_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bit done = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      done = last_ack;
    end
    check_eq("cpu_txn_done", {31'd0, done}, 32'd1);
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int zeros, first, cnt;
    for (int i = 0; i < 1024; i++) begin
      vram_mem[i] = i[7:0];
      ref_mem[i]  = i[7:0];
    end
    reset = 1'b1; blank = 1'b0; cyc = 0; m_rdata = '0;
    bus.scan_req = 1'b0; bus.scan_addr = '0; bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.vram_rdata = '0;
    @(posedge clk); #1;
    apply_reset(3);

    // Idle
    repeat (10) cycle();

    // Scanout stream in active video
    blank = 1'b0; bus.scan_req = 1'b1; bus.scan_addr = 19'h100;
    cnt = 0;
    for (int k = 0; k < 10 && cnt < 3; k++) begin
      cycle();
      if (last_sg) begin cnt++; bus.scan_addr = bus.scan_addr + 19'd1; end
    end
    bus.scan_req = 1'b0;
    repeat (4) cycle();

    // CPU write then read during blanking with scanout also asking
    blank = 1'b1; bus.scan_req = 1'b1; bus.scan_addr = 19'h200;
    cpu_txn(1'b1, 19'h2A, 8'h5C);
    cpu_txn(1'b0, 19'h2A, 8'h00);
    check_eq("blank_rd_data", {24'd0, bus.cpu_rdata}, 32'h5C);

    // Starvation: continuous scanout in active video
    blank = 1'b0; bus.scan_req = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h2A;
    zeros = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (!obs_gnt) begin zeros++; if (first < 0) first = i; end
      if (last_sg) bus.scan_addr = bus.scan_addr + 19'd1;
      if (last_ack) bus.cpu_req = 1'b0;
    end
    check_eq("starve_gap_count", zeros, 32'd1);
    check_eq("starve_gap_pos", first, 32'd16);
    check_eq("starve_rd_data", {24'd0, bus.cpu_rdata}, 32'h5C);
    bus.scan_req = 1'b0;
    repeat (4) cycle();

    // Held CPU request across ack: one access per busy window
    blank = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h10;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_en) cnt++;
    end
    check_eq("held_req_accesses", cnt, 32'd2);
    bus.cpu_req = 1'b0;
    repeat (4) cycle();

    // Reset with a scan read and a CPU read in flight
    blank = 1'b0; bus.scan_req = 1'b1; bus.scan_addr = 19'h55;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h77;
    cycle();
    bus.scan_req = 1'b0;
    cycle();
    apply_reset(2);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_sv || obs_ack) cnt++;
    end
    check_eq("post_reset_pulses", cnt, 32'd0);

    // Randomized mixed traffic with blank toggling
    for (int i = 0; i < 2000; i++) begin
      if (bus.cpu_req && last_ack) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.cpu_we    = $urandom_range(0, 1) == 1;
          bus.cpu_addr  = 19'($urandom_range(0, 1023));
          bus.cpu_wdata = 8'($urandom_range(0, 255));
        end else begin
          bus.cpu_req = 1'b0;
        end
      end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = $urandom_range(0, 1) == 1;
        bus.cpu_addr  = 19'($urandom_range(0, 1023));
        bus.cpu_wdata = 8'($urandom_range(0, 255));
      end
      if (!bus.scan_req || last_sg) begin
        bus.scan_req  = $urandom_range(0, 3) != 0;
        bus.scan_addr = 19'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      cycle();
    end
    bus.scan_req = 1'b0;
    bus.cpu_req  = 1'b0;
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
